// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator memory port slice:
// requester indices and the arbiter FSM state encoding.
package accel_pkg;

    localparam int REQ_HOST = 0;
    localparam int REQ_A    = 1;
    localparam int REQ_B    = 2;
    localparam int REQ_C    = 3;

    typedef logic [0:0] state_t;

    localparam state_t ST_ARB    = 1'b0;
    localparam state_t ST_LOCKED = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr,
// wrapping modulo N; one-hot grant plus winner index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner
);

    logic found;
    int   idx;

    // Scan from ptr upward, first hit wins
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered SRAM port among NUM_REQ requesters
// with round-robin grants, lockable bursts and read routing.
module mem_port_arbiter
    import accel_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [CNT_WIDTH-1:0]          conflict_cnt,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t          state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   owner_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [PW-1:0]      arb_winner;
    logic [PW-1:0]      win;
    logic               accept;

    logic            t1_vld, t1_rd;
    logic [PW-1:0]   t1_idx;
    logic            t2_vld, t2_rd;
    logic [PW-1:0]   t2_idx;
    logic            rd_hit;
    int              pop;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
        if (x == PW'(NUM_REQ - 1)) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    // Grant selection: locked owner bypasses round-robin
    always_comb begin
        req_ready = '0;
        win       = owner_q;
        if (!rst_n) begin
            req_ready = '0;
        end else if (state_q == ST_LOCKED) begin
            req_ready[owner_q] = req_valid[owner_q];
        end else begin
            req_ready = arb_grant;
            win       = arb_winner;
        end
    end

    assign accept = |req_ready;

    // FSM, round-robin pointer and burst owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (accept) begin
                        rr_ptr_q <= next_idx(win);
                        if (req_lock[win]) begin
                            state_q <= ST_LOCKED;
                            owner_q <= win;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!req_valid[owner_q] || !req_lock[owner_q]) begin
                        state_q  <= ST_ARB;
                        rr_ptr_q <= next_idx(owner_q);
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    // Registered SRAM command from the accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= accept;
            if (accept) begin
                mem_we    <= req_we[win];
                mem_addr  <= req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata <= req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    // Two-stage tag pipe tracking who gets the read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_vld <= 1'b0;
            t1_rd  <= 1'b0;
            t1_idx <= '0;
            t2_vld <= 1'b0;
            t2_rd  <= 1'b0;
            t2_idx <= '0;
        end else begin
            t1_vld <= accept;
            t1_rd  <= accept & ~req_we[win];
            t1_idx <= win;
            t2_vld <= t1_vld;
            t2_rd  <= t1_rd;
            t2_idx <= t1_idx;
        end
    end

    assign rd_hit = t2_vld & t2_rd;

    // Route SRAM read data back to the issuing requester
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (rd_hit) begin
            rsp_valid[t2_idx] = 1'b1;
            rsp_data          = mem_rdata;
        end
    end

    // Number of requesters asking this cycle
    always_comb begin
        pop = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop = pop + int'(req_valid[i]);
        end
    end

    // Saturating contention and per-requester grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            grant_cnt    <= '0;
        end else begin
            if (pop >= 2 && conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] &&
                    grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] != '1) begin
                    grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] <=
                        grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural
// one-cycle SRAM and hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 16;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_we;
    logic [NR-1:0]     req_lock;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic [CW-1:0]     conflict_cnt;
    logic [NR*CW-1:0]  grant_cnt;

    logic [DW-1:0] sram [1024];

    int n_chk;
    int n_err;

    mem_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt),
        .grant_cnt    (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency synchronous SRAM
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                sram[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        for (int i = 0; i < 1024; i++) sram[i] = '0;
        sram[5]   = 32'hDEADBEEF;
        mem_rdata = '0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        step();
        step();
        chk("rst_mem_en", 64'(mem_en), 64'h0);
        chk("rst_rsp", 64'(rsp_valid), 64'h0);
        chk("rst_conf", 64'(conflict_cnt), 64'h0);
        chk("rst_gcnt", grant_cnt, 64'h0);

        // Round-robin order from ptr 0
        rst_n = 1'b1;
        #1 chk("rr0", 64'(req_ready), 64'h1);
        step();
        chk("rr1", 64'(req_ready), 64'h2);
        step();
        chk("rr2", 64'(req_ready), 64'h4);
        step();
        chk("rr3", 64'(req_ready), 64'h8);
        step();
        req_valid = '0;
        chk("conf4", 64'(conflict_cnt), 64'd4);
        chk("gcnt4", grant_cnt, 64'h0001_0001_0001_0001);
        chk("en_after", 64'(mem_en), 64'h1);
        step();
        chk("en_idle", 64'(mem_en), 64'h0);
        step();
        step();

        // Read latency, requester 1, ptr 0
        req_valid = 4'b0010;
        req_addr[1*AW +: AW] = 10'h005;
        #1 chk("rd_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = '0;
        chk("rd_en", 64'(mem_en), 64'h1);
        chk("rd_we", 64'(mem_we), 64'h0);
        chk("rd_addr", 64'(mem_addr), 64'h5);
        chk("rd_rsp1", 64'(rsp_valid), 64'h0);
        step();
        chk("rd_rsp2", 64'(rsp_valid), 64'h2);
        chk("rd_data", 64'(rsp_data), 64'hDEADBEEF);
        step();
        chk("rd_rsp3", 64'(rsp_valid), 64'h0);
        chk("rd_en3", 64'(mem_en), 64'h0);

        // Write, read, write back-to-back on requester 3, ptr 2
        req_valid = 4'b1000;
        req_we    = 4'b1000;
        req_addr[3*AW +: AW]  = 10'h007;
        req_wdata[3*DW +: DW] = 32'h1111_2222;
        #1 chk("b2b_rdy0", 64'(req_ready), 64'h8);
        step();
        chk("b2b_en0", 64'(mem_en), 64'h1);
        chk("b2b_we0", 64'(mem_we), 64'h1);
        chk("b2b_ad0", 64'(mem_addr), 64'h7);
        chk("b2b_wd0", 64'(mem_wdata), 64'h1111_2222);
        req_we = 4'b0000;
        #1 chk("b2b_rdy1", 64'(req_ready), 64'h8);
        step();
        chk("b2b_en1", 64'(mem_en), 64'h1);
        chk("b2b_we1", 64'(mem_we), 64'h0);
        chk("b2b_rsp1", 64'(rsp_valid), 64'h0);
        req_we = 4'b1000;
        req_addr[3*AW +: AW]  = 10'h008;
        req_wdata[3*DW +: DW] = 32'h3333_4444;
        #1 chk("b2b_rdy2", 64'(req_ready), 64'h8);
        step();
        req_valid = '0;
        req_we    = '0;
        chk("b2b_we2", 64'(mem_we), 64'h1);
        chk("b2b_ad2", 64'(mem_addr), 64'h8);
        chk("b2b_wd2", 64'(mem_wdata), 64'h3333_4444);
        chk("b2b_rsp2", 64'(rsp_valid), 64'h8);
        chk("b2b_dat2", 64'(rsp_data), 64'h1111_2222);
        step();
        chk("b2b_rsp3", 64'(rsp_valid), 64'h0);
        step();

        // Locked burst by requester 2 while 0 waits, ptr 0
        req_valid = 4'b0100;
        req_lock  = 4'b0100;
        #1 chk("lk_t1", 64'(req_ready), 64'h4);
        step();
        req_valid = 4'b0101;
        #1 chk("lk_t2", 64'(req_ready), 64'h4);
        step();
        chk("lk_t3", 64'(req_ready), 64'h4);
        step();
        req_lock = '0;
        #1 chk("lk_t4", 64'(req_ready), 64'h4);
        step();
        chk("lk_host", 64'(req_ready), 64'h1);
        step();
        chk("lk_next", 64'(req_ready), 64'h4);
        step();
        req_valid = '0;
        step();
        step();

        // Owner drops valid mid-burst, ptr 3
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        req_addr[1*AW +: AW] = 10'h005;
        req_addr[0*AW +: AW] = 10'h000;
        #1 chk("dr_t1", 64'(req_ready), 64'h2);
        step();
        req_valid = 4'b0011;
        #1 chk("dr_t2", 64'(req_ready), 64'h2);
        step();
        req_valid = 4'b0001;
        #1 chk("dr_gap", 64'(req_ready), 64'h0);
        chk("dr_rsp1", 64'(rsp_valid), 64'h2);
        chk("dr_dat1", 64'(rsp_data), 64'hDEADBEEF);
        step();
        chk("dr_arb", 64'(req_ready), 64'h1);
        chk("dr_rsp2", 64'(rsp_valid), 64'h2);
        step();
        req_valid = '0;
        req_lock  = '0;
        chk("dr_rsp3", 64'(rsp_valid), 64'h0);
        step();
        step();

        // Reset one cycle after an accepted read, ptr 1
        req_valid = 4'b0010;
        #1 chk("mr_ready", 64'(req_ready), 64'h2);
        step();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mr_ready0", 64'(req_ready), 64'h0);
        chk("mr_en", 64'(mem_en), 64'h0);
        chk("mr_addr", 64'(mem_addr), 64'h0);
        chk("mr_rsp", 64'(rsp_valid), 64'h0);
        chk("mr_data", 64'(rsp_data), 64'h0);
        chk("mr_gcnt", grant_cnt, 64'h0);
        step();
        chk("mr_rsp2", 64'(rsp_valid), 64'h0);
        req_valid = '0;
        step();

        // Grant counter saturation on requester 0
        rst_n = 1'b1;
        force dut.grant_cnt = 64'h0000_0000_0000_FFFE;
        #1 release dut.grant_cnt;
        req_valid = 4'b0001;
        #1 chk("sat_r0", 64'(req_ready), 64'h1);
        step();
        chk("sat_r1", 64'(req_ready), 64'h1);
        step();
        chk("sat_r2", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        chk("sat_cnt", grant_cnt, 64'h0000_0000_0000_FFFF);
        chk("sat_conf", 64'(conflict_cnt), 64'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_REQ, 4, requester count (0 host, 1 A-read, 2 B-read, 3 C-write); ADDR_WIDTH, 10, SRAM address bits; DATA_WIDTH, 32, SRAM word bits; CNT_WIDTH, 16, metric counter bits.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester access request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  hold grant for burst
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot grant; combinational
- rsp_valid  out  NUM_REQ  read-data pulse
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters
- mem_en  out  1  SRAM enable, registered
- mem_we  out  1  SRAM write enable, registered
- mem_addr  out  ADDR_WIDTH  SRAM address, registered
- mem_wdata  out  DATA_WIDTH  SRAM write data, registered
- mem_rdata  in  DATA_WIDTH  SRAM read data, valid 1 cycle after mem_en with mem_we = 0
- conflict_cnt  out  CNT_WIDTH  cycles with at least 2 requests pending
- grant_cnt  out  NUM_REQ*CNT_WIDTH  accepted transfers per requester
REQ-003 SHALL use reset rst_n, asynchronous, active-low, and clock clk.

Function
REQ-004 SHALL accept a transfer from requester i in cycle t iff req_valid[i] and req_ready[i] are both high in t.
REQ-005 SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid high.
REQ-006 SHALL run the FSM states ARB and LOCKED.
REQ-007 In ARB, SHALL grant round-robin: search starts at rr_ptr and wraps modulo NUM_REQ.
REQ-008 In ARB, after a grant to requester w, SHALL set rr_ptr to (w+1) mod NUM_REQ.
REQ-009 In ARB, SHALL move to LOCKED with owner = w when the grant to w has req_lock[w] high.
REQ-010 In LOCKED, SHALL drive req_ready[owner] = req_valid[owner] and deassert all other req_ready bits.
REQ-011 In LOCKED, SHALL return to ARB in the cycle after a transfer with req_lock[owner] low, or when req_valid[owner] is low.
REQ-012 On return to ARB, rr_ptr SHALL be (owner+1) mod NUM_REQ.
REQ-013 SHALL drive mem_en, mem_we, mem_addr and mem_wdata in cycle t+1 from the transfer accepted in t.
REQ-014 SHALL hold mem_en = 0 in any cycle following a cycle with no accepted transfer.
REQ-015 SHALL pulse rsp_valid[i] in cycle t+2 for a read accepted in t, with rsp_data = mem_rdata.
REQ-016 SHALL never assert rsp_valid for writes.
REQ-017 SHALL sustain one accepted transfer per cycle with no bubble, including back-to-back read, write, read on one port.
REQ-018 SHALL increment conflict_cnt in each cycle where popcount(req_valid) >= 2, saturating at all-ones.
REQ-019 SHALL increment grant_cnt slice i on each transfer accepted from requester i, saturating at all-ones.
REQ-020 SHALL keep in-flight responses valid if the owner drops req_valid mid-burst; responses already issued still return at t+2.

Reset
REQ-021 On rst_n low, SHALL set state ARB, rr_ptr = 0 and owner = 0.
REQ-022 On rst_n low, SHALL clear mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, the pipeline tags, conflict_cnt and grant_cnt.
REQ-023 SHALL hold req_ready = 0 while rst_n is low.
REQ-024 On reset mid-operation, SHALL drop in-flight reads with no rsp_valid generated.

Structure
REQ-025 SHALL define the requester index constants (REQ_HOST, REQ_A, REQ_B, REQ_C) and the FSM state typedef in shared package accel_pkg.
REQ-026 SHALL implement round-robin selection in one sub-module rr_arbiter (inputs: req vector and ptr; outputs: one-hot grant and winner index).
REQ-027 SHALL carry a 2-stage tag pipeline (valid, read flag, requester index) to route responses.

Verification
REQ-028 Reset: rr_ptr = 0; req_valid = 4'b1111 for 4 cycles, req_lock = 0 -> grants in order 0,1,2,3; conflict_cnt = 4.
REQ-029 Read latency: requester 1 reads addr 0x005 at t with SRAM model word 0x5 = 0xDEADBEEF -> mem_en/addr 0x005 at t+1; rsp_valid = 4'b0010 and rsp_data = 0xDEADBEEF at t+2.
REQ-030 Lock burst: requester 2 holds req_lock for 4 transfers while requester 0 is valid -> 0 is granted only after the 4th transfer; then rr_ptr = 3.
REQ-031 Owner drops req_valid mid-burst -> FSM returns to ARB next cycle; no stall; pending rsp_valid still arrives at t+2.
REQ-032 Saturation: force grant_cnt slice 0 = 0xFFFE, then make 3 accepted transfers from requester 0 -> slice 0 reads 0xFFFF.
REQ-033 Reset mid-read: rst_n low at t+1 after a read is accepted at t -> rsp_valid stays 0 and all outputs are 0.
